// File: rtl/booth_r4_pkg.sv
// Purpose: shared types and constants for the radix-4 Booth decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package booth_r4_pkg;

    // Default number of radix-4 digits per encoded word.
    localparam int NDIG_DEFAULT = 4;

    // Decoder control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Raw triplet encodings {x[2i+1], x[2i], x[2i-1]}.
    localparam logic [2:0] TRIP_ZERO_A = 3'b000;  //  0
    localparam logic [2:0] TRIP_POS1_A = 3'b001;  // +1
    localparam logic [2:0] TRIP_POS1_B = 3'b010;  // +1
    localparam logic [2:0] TRIP_POS2   = 3'b011;  // +2
    localparam logic [2:0] TRIP_NEG2   = 3'b100;  // -2
    localparam logic [2:0] TRIP_NEG1_A = 3'b101;  // -1
    localparam logic [2:0] TRIP_NEG1_B = 3'b110;  // -1
    localparam logic [2:0] TRIP_ZERO_B = 3'b111;  //  0

endpackage

// File: rtl/booth_r4_digit.sv
// Purpose: map one Booth radix-4 triplet to its signed digit value.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
// Ports: trip (3-bit raw triplet in), dig (signed digit in -2..+2 out).
module booth_r4_digit
    import booth_r4_pkg::*;
(
    input  logic [2:0]        trip,
    output logic signed [2:0] dig
);

    always_comb begin
        dig = 3'sd0;
        case (trip)
            TRIP_ZERO_A: dig =  3'sd0;
            TRIP_POS1_A: dig =  3'sd1;
            TRIP_POS1_B: dig =  3'sd1;
            TRIP_POS2:   dig =  3'sd2;
            TRIP_NEG2:   dig = -3'sd2;
            TRIP_NEG1_A: dig = -3'sd1;
            TRIP_NEG1_B: dig = -3'sd1;
            TRIP_ZERO_B: dig =  3'sd0;
            default:     dig =  3'sd0;
        endcase
    end

endmodule

// File: rtl/booth_r4_decoder.sv
// Purpose: reconstruct a two's-complement value from a radix-4 Booth encoded word.
// Latency: out_valid rises NDIG edges after the capture edge; one digit folded per cycle.
// Backpressure: single-entry; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, reset (sync, active-high); in_valid/in_ready/y_in (3*NDIG-bit encoded word in);
//        out_valid/out_ready/x_out (2*NDIG-bit value)/digit_err (illegal-encoding flag).
module booth_r4_decoder
    import booth_r4_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT,
    localparam int XW  = 2 * NDIG
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [3*NDIG-1:0]   y_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XW-1:0]       x_out,
    output logic                digit_err
);

    localparam int AW = XW + 2;
    localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t                state_q;
    state_t                state_d;
    logic [3*NDIG-1:0]     sreg;
    logic signed [AW-1:0]  acc;
    logic [CW-1:0]         cnt;
    logic                  err_q;
    logic                  err_calc;
    logic signed [2:0]     dig_val;
    logic signed [AW-1:0]  dig_ext;
    logic                  capture;

    // The shift register presents the most significant unfolded triplet at its top,
    // so a single digit mapper serves every Horner step.
    booth_r4_digit u_digit (
        .trip (sreg[3*NDIG-1 -: 3]),
        .dig  (dig_val)
    );

    assign dig_ext = AW'(dig_val);

    // Legal encodings chain: each triplet's low bit repeats the previous triplet's
    // high bit, and the first triplet's low bit is the implicit x[-1] = 0.
    always_comb begin
        err_calc = y_in[0];
        for (int i = 1; i < NDIG; i++) begin
            err_calc = err_calc | (y_in[3*i] ^ y_in[3*i-1]);
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ACC;
            end
            ACC: begin
                if (cnt == '0) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign capture = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg  <= '0;
            acc   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (capture) begin
                sreg  <= y_in;
                acc   <= '0;
                cnt   <= CW'(NDIG - 1);
                err_q <= err_calc;
            end else if (state_q == ACC) begin
                // Horner step; truncation of the top bits is intended for illegal words.
                acc  <= (acc <<< 2) + dig_ext;
                sreg <= sreg << 3;
                cnt  <= cnt - CW'(1);
            end
        end
    end

    assign x_out     = acc[XW-1:0];
    assign digit_err = err_q;

endmodule

// File: tb/tb_booth_r4_decoder.sv
module tb_booth_r4_decoder;

    localparam int NDIG = 4;
    localparam int XW   = 2 * NDIG;

    logic                clk;
    logic                reset;
    logic                in_valid;
    logic                in_ready;
    logic [3*NDIG-1:0]   y_in;
    logic                out_valid;
    logic                out_ready;
    logic [XW-1:0]       x_out;
    logic                digit_err;

    int checks = 0;
    int errors = 0;

    booth_r4_decoder #(.NDIG(NDIG)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .digit_err (digit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3*NDIG-1:0] y;
        logic [XW-1:0]     x;
        logic              err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference encoder: triplet i is x[2i+1:2i-1] with x[-1] = 0.
    function automatic logic [3*NDIG-1:0] encode(input logic [XW-1:0] x);
        logic [XW:0]       xe;
        logic [3*NDIG-1:0] y;
        xe = {x, 1'b0};
        y  = '0;
        for (int i = 0; i < NDIG; i++) y[3*i +: 3] = xe[2*i +: 3];
        return y;
    endfunction

    // Reference decode by plain arithmetic: digit = -2*b2 + b1 + b0, weight 4^i.
    function automatic logic [XW-1:0] ref_value(input logic [3*NDIG-1:0] y);
        int s;
        int d;
        s = 0;
        for (int i = 0; i < NDIG; i++) begin
            d = -2 * int'(y[3*i+2]) + int'(y[3*i+1]) + int'(y[3*i]);
            s = s + d * (4 ** i);
        end
        return XW'(s);
    endfunction

    function automatic logic ref_err(input logic [3*NDIG-1:0] y);
        logic e;
        e = (y[0] != 1'b0);
        for (int i = 1; i < NDIG; i++) if (y[3*i] != y[3*(i-1)+2]) e = 1'b1;
        return e;
    endfunction

    // Sends one word from IDLE, checks latency and result, then completes the handshake.
    task automatic run_word(input string name, input logic [3*NDIG-1:0] y,
                            input logic [XW-1:0] ex, input logic ee);
        int n;
        logic got;
        chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
        y_in = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        y_in = 12'($urandom);
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            n++;
            got = out_valid;
        end
        chk({name, "_latency"}, 32'(n), 32'(NDIG));
        chk({name, "_x"}, 32'(x_out), 32'(ex));
        chk({name, "_err"}, 32'(digit_err), 32'(ee));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_post_vld"}, 32'(out_valid), 32'd0);
        chk({name, "_post_rdy"}, 32'(in_ready), 32'd1);
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk({name, "_quiet"}, 32'(seen), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        logic [XW-1:0]     xr;
        logic [3*NDIG-1:0] yr;

        vecs[0] = '{y: 12'h000, x: 8'h00, err: 1'b0};
        vecs[1] = '{y: 12'h7FE, x: 8'h7F, err: 1'b0};
        vecs[2] = '{y: 12'h800, x: 8'h80, err: 1'b0};
        vecs[3] = '{y: 12'h001, x: 8'h01, err: 1'b1};
        vecs[4] = '{y: 12'h492, x: 8'h55, err: 1'b0};
        vecs[5] = '{y: 12'hFFF, x: 8'h00, err: 1'b1};

        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        y_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_x_out", 32'(x_out), 32'd0);
        chk("rst_digit_err", 32'(digit_err), 32'd0);
        reset = 1'b0;

        // out_ready while nothing is pending has no effect
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("idle_ordy_vld", 32'(out_valid), 32'd0);
        chk("idle_ordy_rdy", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            run_word($sformatf("vec%0d", i), vecs[i].y, vecs[i].x, vecs[i].err);
        end

        // Backpressure: result held for 3 cycles, in_valid pulses ignored
        y_in = 12'h7FE;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (NDIG) @(posedge clk);
        #1;
        chk("bp_first_vld", 32'(out_valid), 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            y_in = 12'h800;
            @(posedge clk); #1;
            chk($sformatf("bp_vld%0d", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_x%0d", i), 32'(x_out), 32'h7F);
            chk($sformatf("bp_err%0d", i), 32'(digit_err), 32'd0);
            chk($sformatf("bp_rdy%0d", i), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_post_vld", 32'(out_valid), 32'd0);
        chk("bp_post_rdy", 32'(in_ready), 32'd1);
        expect_quiet("bp", NDIG + 2);

        // Reset during the second ACC cycle discards the word
        y_in = 12'h7FE;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("racc_rdy", 32'(in_ready), 32'd1);
        chk("racc_vld", 32'(out_valid), 32'd0);
        chk("racc_x", 32'(x_out), 32'd0);
        chk("racc_err", 32'(digit_err), 32'd0);
        expect_quiet("racc", NDIG + 2);

        // Reset in DONE overrides a simultaneous handshake
        y_in = 12'h001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (NDIG) @(posedge clk);
        #1;
        chk("rdone_vld_before", 32'(out_valid), 32'd1);
        reset = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b0;
        chk("rdone_rdy", 32'(in_ready), 32'd1);
        chk("rdone_vld", 32'(out_valid), 32'd0);
        chk("rdone_x", 32'(x_out), 32'd0);
        chk("rdone_err", 32'(digit_err), 32'd0);

        // Random legal words from the reference encoder must round-trip
        for (int i = 0; i < 10; i++) begin
            xr = XW'($urandom_range(0, 255));
            run_word($sformatf("rnd%0d_%02h", i, xr), encode(xr), xr, 1'b0);
        end

        // Random raw words, legal or not, against the arithmetic model
        for (int i = 0; i < 10; i++) begin
            yr = 12'($urandom);
            run_word($sformatf("raw%0d_%03h", i, yr), yr, ref_value(yr), ref_err(yr));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
